// File: rtl/branch_update_scheduler_pkg.sv
// Shared definitions for the branch-buffer update path.
//   - Field widths of a branch-buffer entry (tag, index, target, type).
//   - 2-bit direction-counter encodings (SNT/WNT/WT/ST).
//   - upd_t: packed resolved-branch update {tag, index, tar, type, dir, mispred},
//     66 bits, the unit stored in the update FIFO.
//   - FSM state encoding for the scheduler.
package branch_update_scheduler_pkg;

  localparam int IDX_W  = 8;
  localparam int TAG_W  = 22;
  localparam int TAR_W  = 32;
  localparam int TYPE_W = 2;

  localparam logic [1:0] DIR_SNT = 2'b00;
  localparam logic [1:0] DIR_WNT = 2'b01;
  localparam logic [1:0] DIR_WT  = 2'b10;
  localparam logic [1:0] DIR_ST  = 2'b11;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [IDX_W-1:0]  index;
    logic [TAR_W-1:0]  tar;
    logic [TYPE_W-1:0] btype;
    logic              dir;
    logic              mispred;
  } upd_t;

  localparam int UPD_W = $bits(upd_t);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  function automatic upd_t pack_upd(input logic [TAG_W-1:0]  tag,
                                    input logic [IDX_W-1:0]  index,
                                    input logic [TAR_W-1:0]  tar,
                                    input logic [TYPE_W-1:0] btype,
                                    input logic              dir,
                                    input logic              mispred);
    upd_t u;
    u.tag     = tag;
    u.index   = index;
    u.tar     = tar;
    u.btype   = btype;
    u.dir     = dir;
    u.mispred = mispred;
    return u;
  endfunction

endpackage

// File: rtl/branch_update_scheduler_fifo.sv
// bu_fifo: DEPTH-entry update queue with two ordered write ports and one
// read port.
//   clk, resetn        clock, asynchronous active-low reset (pointers/count only)
//   wr0_en/wr0_data    first write of the cycle
//   wr1_en/wr1_data    second write of the cycle, stored after wr0
//   rd_en              pop the head this cycle
//   rd_data            current head entry (combinational)
//   count              occupancy, 0..DEPTH
// Full and empty are told apart by count, never by pointer equality. The
// caller guarantees it never overflows or underflows the queue.
module bu_fifo
  import branch_update_scheduler_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = UPD_W
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       wr0_en,
  input  logic [W-1:0]               wr0_data,
  input  logic                       wr1_en,
  input  logic [W-1:0]               wr1_data,
  input  logic                       rd_en,
  output logic [W-1:0]               rd_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic [PTR_W-1:0] wptr_second;
  logic [PTR_W-1:0] n_wr;

  // Slot-1 lands just after slot-0 when both write; DEPTH is a power of two,
  // so pointer arithmetic wraps naturally.
  always_comb begin
    n_wr        = PTR_W'(wr0_en) + PTR_W'(wr1_en);
    wptr_second = wptr + PTR_W'(wr0_en);
    rd_data     = mem[rptr];
  end

  always_ff @(posedge clk) begin
    if (wr0_en) mem[wptr] <= wr0_data;
    if (wr1_en) mem[wptr_second] <= wr1_data;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      wptr  <= wptr + n_wr;
      rptr  <= rptr + PTR_W'(rd_en);
      count <= count + CNT_W'(wr0_en) + CNT_W'(wr1_en) - CNT_W'(rd_en);
    end
  end

endmodule

// File: rtl/branch_update_scheduler.sv
// branch_update_scheduler: sole writer of the 256-entry direct-mapped branch
// buffer.
//   clk, resetn              clock, asynchronous active-low reset
//   upd0_* / upd1_*          resolved branches from the dual-issue ID stage
//                            (valid, index, tag, tar, type, dir, mispred)
//   stall_req                <2 free queue slots next cycle, or init sweep active
//   init_busy                init sweep active; updates are ignored
//   wr_en                    direction-counter update strobe
//   wr_entry_en              tag/target/type/valid rewrite strobe
//   wr_init                  init write (buffer forces dir=INIT_DIR, valid=0)
//   wr_index/tag/tar/type    write address and entry data
//   wr_dir                   taken bit for the counter step
//   wr_valid                 valid bit to store (zero target never validates)
//   drop_cnt                 saturating count of updates rejected for space
// After reset the whole table is swept once (the buffer does not clear on
// reset). Then up to two updates per cycle are queued and one write per
// cycle is issued, registered.
module branch_update_scheduler
  import branch_update_scheduler_pkg::*;
#(
  parameter int         DEPTH    = 4,
  parameter logic [1:0] INIT_DIR = DIR_WNT
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              upd0_valid,
  input  logic [IDX_W-1:0]  upd0_index,
  input  logic [TAG_W-1:0]  upd0_tag,
  input  logic [TAR_W-1:0]  upd0_tar,
  input  logic [TYPE_W-1:0] upd0_type,
  input  logic              upd0_dir,
  input  logic              upd0_mispred,
  input  logic              upd1_valid,
  input  logic [IDX_W-1:0]  upd1_index,
  input  logic [TAG_W-1:0]  upd1_tag,
  input  logic [TAR_W-1:0]  upd1_tar,
  input  logic [TYPE_W-1:0] upd1_type,
  input  logic              upd1_dir,
  input  logic              upd1_mispred,
  output logic              stall_req,
  output logic              init_busy,
  output logic              wr_en,
  output logic              wr_entry_en,
  output logic              wr_init,
  output logic [IDX_W-1:0]  wr_index,
  output logic [TAG_W-1:0]  wr_tag,
  output logic [TAR_W-1:0]  wr_tar,
  output logic [TYPE_W-1:0] wr_type,
  output logic              wr_dir,
  output logic              wr_valid,
  output logic [7:0]        drop_cnt
);

  localparam int              CNT_W    = $clog2(DEPTH+1);
  localparam int              FREE_W   = CNT_W + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = {IDX_W{1'b1}};

  function automatic logic [7:0] sat_add_u8(input logic [7:0] a,
                                            input logic [1:0] inc);
    logic [8:0] s;
    s = {1'b0, a} + {7'b0, inc};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

  state_t           state;
  state_t           state_next;
  logic [IDX_W-1:0] sweep_ptr;

  logic [CNT_W-1:0]  fifo_cnt;
  logic [CNT_W-1:0]  cnt_next;
  logic [FREE_W-1:0] free;
  logic              run;
  logic              fifo_nonempty;
  logic              acc0;
  logic              acc1;
  logic [1:0]        ndrop;
  upd_t              u0;
  upd_t              u1;
  upd_t              first_acc;
  upd_t              fifo_head;
  upd_t              fifo_wr0_data;
  upd_t              fifo_wr1_data;
  logic              fifo_wr0_en;
  logic              fifo_wr1_en;
  logic              fifo_rd_en;
  upd_t              wr_sel_p0;
  logic              vld_p0;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= ST_INIT;
    else         state <= state_next;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_next = state;
    case (state)
      ST_INIT: if (sweep_ptr == LAST_IDX) state_next = ST_RUN;
      ST_RUN:  state_next = ST_RUN;
      default: state_next = ST_INIT;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    init_busy = (state == ST_INIT);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)               sweep_ptr <= '0;
    else if (state == ST_INIT) sweep_ptr <= sweep_ptr + 1'b1;
  end

  // ---------------- p0: accept, queue and pick this cycle's write ----------------
  // The head leaves every cycle the queue is non-empty, which frees a slot
  // for this cycle's arrivals. With an empty queue the first accepted update
  // bypasses straight to the output register, so latency is one cycle.
  always_comb begin
    u0 = pack_upd(upd0_tag, upd0_index, upd0_tar, upd0_type, upd0_dir, upd0_mispred);
    u1 = pack_upd(upd1_tag, upd1_index, upd1_tar, upd1_type, upd1_dir, upd1_mispred);

    run           = (state == ST_RUN);
    fifo_nonempty = (fifo_cnt != '0);
    free          = FREE_W'(DEPTH) - FREE_W'(fifo_cnt) + FREE_W'(fifo_nonempty);

    acc0 = run && upd0_valid && (free >= FREE_W'(1));
    acc1 = run && upd1_valid && (free >= (acc0 ? FREE_W'(2) : FREE_W'(1)));

    ndrop = {1'b0, run && upd0_valid && !acc0} + {1'b0, run && upd1_valid && !acc1};

    first_acc = acc0 ? u0 : u1;

    fifo_rd_en    = fifo_nonempty;
    fifo_wr0_en   = 1'b0;
    fifo_wr0_data = u1;
    fifo_wr1_en   = 1'b0;
    fifo_wr1_data = u1;
    vld_p0        = 1'b0;
    wr_sel_p0     = fifo_head;

    if (fifo_nonempty) begin
      vld_p0        = 1'b1;
      wr_sel_p0     = fifo_head;
      fifo_wr0_en   = acc0 || acc1;
      fifo_wr0_data = first_acc;
      fifo_wr1_en   = acc0 && acc1;
      fifo_wr1_data = u1;
    end else begin
      vld_p0        = acc0 || acc1;
      wr_sel_p0     = first_acc;
      fifo_wr0_en   = acc0 && acc1;
      fifo_wr0_data = u1;
    end

    cnt_next = fifo_cnt + CNT_W'(acc0) + CNT_W'(acc1) - CNT_W'(vld_p0);
  end

  bu_fifo #(
    .DEPTH (DEPTH),
    .W     (UPD_W)
  ) u_fifo (
    .clk      (clk),
    .resetn   (resetn),
    .wr0_en   (fifo_wr0_en),
    .wr0_data (fifo_wr0_data),
    .wr1_en   (fifo_wr1_en),
    .wr1_data (fifo_wr1_data),
    .rd_en    (fifo_rd_en),
    .rd_data  (fifo_head),
    .count    (fifo_cnt)
  );

  // ---------------- p1: registered status ----------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stall_req <= 1'b1;
      drop_cnt  <= '0;
    end else begin
      stall_req <= (state_next == ST_INIT) || (cnt_next > CNT_W'(DEPTH - 2));
      drop_cnt  <= sat_add_u8(drop_cnt, ndrop);
    end
  end

  // ---------------- p1: registered write port ----------------
  // Init writes carry the taken-ness of INIT_DIR on wr_dir (0 for WNT); the
  // buffer itself loads the full INIT_DIR value when wr_init is set.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_en       <= 1'b0;
      wr_entry_en <= 1'b0;
      wr_init     <= 1'b0;
      wr_index    <= '0;
      wr_tag      <= '0;
      wr_tar      <= '0;
      wr_type     <= '0;
      wr_dir      <= 1'b0;
      wr_valid    <= 1'b0;
    end else if (state == ST_INIT) begin
      wr_en       <= 1'b1;
      wr_entry_en <= 1'b0;
      wr_init     <= 1'b1;
      wr_index    <= sweep_ptr;
      wr_tag      <= '0;
      wr_tar      <= '0;
      wr_type     <= '0;
      wr_dir      <= INIT_DIR[1];
      wr_valid    <= 1'b0;
    end else begin
      wr_en       <= vld_p0;
      wr_entry_en <= vld_p0 && wr_sel_p0.mispred;
      wr_init     <= 1'b0;
      if (vld_p0) begin
        wr_index <= wr_sel_p0.index;
        wr_tag   <= wr_sel_p0.tag;
        wr_tar   <= wr_sel_p0.tar;
        wr_type  <= wr_sel_p0.btype;
        wr_dir   <= wr_sel_p0.dir;
        wr_valid <= |wr_sel_p0.tar;
      end
    end
  end

endmodule

// File: tb/tb_branch_update_scheduler.sv
module tb_branch_update_scheduler;

  localparam int DEPTH = 4;

  logic        clk;
  logic        resetn;
  logic        upd0_valid, upd1_valid;
  logic [7:0]  upd0_index, upd1_index;
  logic [21:0] upd0_tag, upd1_tag;
  logic [31:0] upd0_tar, upd1_tar;
  logic [1:0]  upd0_type, upd1_type;
  logic        upd0_dir, upd1_dir, upd0_mispred, upd1_mispred;
  logic        stall_req, init_busy, wr_en, wr_entry_en, wr_init;
  logic [7:0]  wr_index;
  logic [21:0] wr_tag;
  logic [31:0] wr_tar;
  logic [1:0]  wr_type;
  logic        wr_dir, wr_valid;
  logic [7:0]  drop_cnt;

  branch_update_scheduler #(.DEPTH(DEPTH), .INIT_DIR(2'b01)) dut (
    .clk(clk), .resetn(resetn),
    .upd0_valid(upd0_valid), .upd0_index(upd0_index), .upd0_tag(upd0_tag),
    .upd0_tar(upd0_tar), .upd0_type(upd0_type), .upd0_dir(upd0_dir),
    .upd0_mispred(upd0_mispred),
    .upd1_valid(upd1_valid), .upd1_index(upd1_index), .upd1_tag(upd1_tag),
    .upd1_tar(upd1_tar), .upd1_type(upd1_type), .upd1_dir(upd1_dir),
    .upd1_mispred(upd1_mispred),
    .stall_req(stall_req), .init_busy(init_busy), .wr_en(wr_en),
    .wr_entry_en(wr_entry_en), .wr_init(wr_init), .wr_index(wr_index),
    .wr_tag(wr_tag), .wr_tar(wr_tar), .wr_type(wr_type), .wr_dir(wr_dir),
    .wr_valid(wr_valid), .drop_cnt(drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic v; logic [7:0] idx; logic [21:0] tag; logic [31:0] tar;
    logic [1:0] typ; logic dir; logic mis;
  } tupd_t;

  typedef struct packed {
    logic init; logic ent; logic [7:0] idx; logic [21:0] tag; logic [31:0] tar;
    logic [1:0] typ; logic dir; logic vld;
  } wrec_t;

  typedef struct packed {
    logic we; logic busy; logic stall; logic [7:0] drop;
  } stat_t;

  wrec_t wq[$];
  stat_t sq[$];
  int    n_vec = 0;
  int    n_err = 0;
  int    init_left;
  int    pend;
  int    m_drop;
  bit    in_reset = 1'b1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic tupd_t mk(input logic v, input logic [7:0] idx, input logic [31:0] tar,
                               input logic dir, input logic mis);
    tupd_t u;
    u.v = v; u.idx = idx; u.tag = 22'h2A5A5 ^ {14'd0, idx}; u.tar = tar;
    u.typ = idx[1:0]; u.dir = dir; u.mis = mis;
    return u;
  endfunction

  function automatic tupd_t rnd(input int pct_valid);
    tupd_t u;
    u.v   = ($urandom_range(0, 99) < pct_valid);
    u.idx = 8'($urandom);
    u.tag = 22'($urandom);
    u.tar = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
    u.typ = 2'($urandom);
    u.dir = 1'($urandom);
    u.mis = 1'($urandom);
    return u;
  endfunction

  // Reference model: a queue of accepted-but-unwritten updates. One write
  // leaves per cycle; after that write at most DEPTH may remain pending.
  task automatic step(input tupd_t a, input tupd_t b);
    tupd_t u[2];
    stat_t s;
    wrec_t r;
    int    nacc, total;
    u[0] = a; u[1] = b;
    upd0_valid = a.v; upd0_index = a.idx; upd0_tag = a.tag; upd0_tar = a.tar;
    upd0_type = a.typ; upd0_dir = a.dir; upd0_mispred = a.mis;
    upd1_valid = b.v; upd1_index = b.idx; upd1_tag = b.tag; upd1_tar = b.tar;
    upd1_type = b.typ; upd1_dir = b.dir; upd1_mispred = b.mis;
    if (init_left > 0) begin
      r = '0;
      r.init = 1'b1;
      r.idx  = 8'(256 - init_left);
      wq.push_back(r);
      init_left--;
      s.we = 1'b1; s.busy = (init_left > 0); s.stall = (init_left > 0); s.drop = 8'(m_drop);
    end else begin
      nacc = 0;
      for (int k = 0; k < 2; k++) begin
        if (u[k].v) begin
          if (pend + nacc <= DEPTH) begin
            r.init = 1'b0; r.ent = u[k].mis; r.idx = u[k].idx; r.tag = u[k].tag;
            r.tar = u[k].tar; r.typ = u[k].typ; r.dir = u[k].dir; r.vld = (u[k].tar != 0);
            wq.push_back(r);
            nacc++;
          end else if (m_drop < 255) begin
            m_drop++;
          end
        end
      end
      total = pend + nacc;
      pend  = (total > 0) ? total - 1 : 0;
      s.we = (total > 0); s.busy = 1'b0; s.stall = ((DEPTH - pend) < 2); s.drop = 8'(m_drop);
    end
    sq.push_back(s);
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step('0, '0);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    in_reset = 1'b1;
    upd0_valid = 1'b0; upd1_valid = 1'b0;
    #1;
    check("rst_wr_en",    {127'd0, wr_en}, 128'd0);
    check("rst_wr_init",  {127'd0, wr_init}, 128'd0);
    check("rst_entry_en", {127'd0, wr_entry_en}, 128'd0);
    check("rst_wr_data",  {62'd0, wr_index, wr_tag, wr_tar, wr_type, wr_dir, wr_valid}, 128'd0);
    check("rst_drop_cnt", {120'd0, drop_cnt}, 128'd0);
    check("rst_busy_stall", {126'd0, init_busy, stall_req}, 128'd3);
    wq.delete();
    sq.delete();
    init_left = 256;
    pend      = 0;
    m_drop    = 0;
    @(posedge clk);
    @(posedge clk);
    #2;
    resetn   = 1'b1;
    in_reset = 1'b0;
  endtask

  // Monitor: per-cycle status plus scoreboard pop whenever a write appears.
  stat_t mon_s;
  wrec_t mon_e, mon_a;
  always @(posedge clk) begin
    #1;
    if (!in_reset && resetn) begin
      if (sq.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL status_queue: got empty required entry (t=%0t)", $time);
      end else begin
        mon_s = sq.pop_front();
        check("wr_en",     {127'd0, wr_en}, {127'd0, mon_s.we});
        check("init_busy", {127'd0, init_busy}, {127'd0, mon_s.busy});
        check("stall_req", {127'd0, stall_req}, {127'd0, mon_s.stall});
        check("drop_cnt",  {120'd0, drop_cnt}, {120'd0, mon_s.drop});
      end
      if (wr_en) begin
        mon_a = {wr_init, wr_entry_en, wr_index, wr_tag, wr_tar, wr_type, wr_dir, wr_valid};
        if (wq.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL write_order: got unexpected write %h required none (t=%0t)", mon_a, $time);
        end else begin
          mon_e = wq.pop_front();
          check("write_rec", {60'd0, mon_a}, {60'd0, mon_e});
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b1;
    upd0_valid = 1'b0; upd1_valid = 1'b0;
    {upd0_index, upd0_tag, upd0_tar, upd0_type, upd0_dir, upd0_mispred} = '0;
    {upd1_index, upd1_tag, upd1_tar, upd1_type, upd1_dir, upd1_mispred} = '0;
    #3;
    do_reset();

    // Init sweep with updates offered throughout (all must be ignored).
    for (int i = 0; i < 256; i++) step(rnd(80), rnd(80));
    idle(2);

    // Single update, one-cycle latency.
    step(mk(1, 8'h12, 32'h8000_0040, 1'b1, 1'b1), '0);
    idle(2);
    // Dual update, slot 0 then slot 1.
    step(mk(1, 8'h05, 32'h0000_1000, 1'b0, 1'b1), mk(1, 8'h06, 32'h0000_2000, 1'b1, 1'b0));
    idle(2);
    // Zero target never validates.
    step(mk(1, 8'h33, 32'd0, 1'b1, 1'b1), '0);
    idle(2);
    // Sustained dual input, stall_req ignored: fills and drops.
    for (int i = 0; i < 6; i++) step(rnd(100), rnd(100));
    idle(8);
    // Same index in both slots.
    step(mk(1, 8'h20, 32'h0000_4000, 1'b1, 1'b1), mk(1, 8'h20, 32'h0000_4004, 1'b0, 1'b1));
    idle(3);

    // Mixed random traffic.
    for (int i = 0; i < 300; i++) step(rnd(55), rnd(55));
    idle(8);
    // Long overload drives drop_cnt into saturation.
    for (int i = 0; i < 270; i++) step(rnd(100), rnd(100));
    idle(8);

    // Reset with three entries queued: queue discarded, sweep restarts at 0.
    for (int i = 0; i < 3; i++) step(rnd(100), rnd(100));
    do_reset();
    for (int i = 0; i < 256; i++) step(rnd(30), rnd(30));
    for (int i = 0; i < 60; i++) step(rnd(60), rnd(60));

    for (int i = 0; i < 20 && pend > 0; i++) idle(1);
    idle(2);
    check("queues_drained", {64'd0, 32'(wq.size()), 32'(sq.size())}, 128'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
